// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: four-digit multiplexed 7-segment driver with per-frame snapshot, leading-zero blanking and scan enable
module bcd_seg_scan #(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic       blank_lz,
   input  logic [3:0] dp_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       scan_tick
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [6:0] PAT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   snap, live, src;
   logic [3:0]    sdp, src_dp, digit;
   logic          pend, last, blank;
   logic [6:0]    seg_d;
   // while the post-reset load is pending the live inputs are that fresh snapshot
   always_comb begin
      live      = {d3, d2, d1, d0};
      src       = pend ? live : snap;
      src_dp    = pend ? dp_mask : sdp;
      digit     = src[{idx, 2'b00} +: 4];
      blank     = blank_lz & ((idx == 2'd3 & src[15:12] == 4'd0) | (idx == 2'd2 & src[15:8] == 8'd0));
      seg_d     = blank ? 7'b1111111 : digit > 4'd9 ? 7'b0111111 : PAT[digit];
      last      = cnt == CW'(SCAN_DIV - 1);
      scan_tick = rst & en & last;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         idx  <= '0;
         snap <= '0;
         sdp  <= '0;
         pend <= 1'b1;
         an   <= 4'b1111;
         seg  <= 7'b1111111;
         dp   <= 1'b1;
      end else if (en) begin
         cnt <= last ? '0 : cnt + CW'(1);
         if (last) idx <= idx + 2'd1;
         an  <= ~(4'b0001 << idx);
         seg <= seg_d;
         dp  <= ~src_dp[idx];
         if (pend | (last & idx == 2'd3)) begin
            snap <= live;
            sdp  <= dp_mask;
            pend <= 1'b0;
         end
      end else begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed and random stimulus checked against a behavioural display model
module tb_bcd_seg_scan;
   localparam int DIV = 4;
   logic       clk, rst, en, blank_lz, scan_tick, dp;
   logic [3:0] d0, d1, d2, d3, dp_mask, an;
   logic [6:0] seg;
   int errors = 0, checks = 0;
   int m_cnt, m_idx, m_snap [4], m_sdp [4];
   bit m_pend;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic e_dp;
   logic [6:0] pat [10];

   bcd_seg_scan #(.SCAN_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .blank_lz(blank_lz), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      int live [4], ldp [4], src [4], sdp [4], v;
      bit tick, blank;
      #1;
      chk("scan_tick", {7'd0, scan_tick}, {7'd0, rst && en && m_cnt == DIV - 1});
      live = '{int'(d0), int'(d1), int'(d2), int'(d3)};
      for (int i = 0; i < 4; i++) ldp[i] = int'(dp_mask[i]);
      if (!rst) begin
         m_cnt = 0; m_idx = 0; m_pend = 1;
         m_snap = '{0, 0, 0, 0}; m_sdp = '{0, 0, 0, 0};
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1;
      end else if (en) begin
         tick = (m_cnt == DIV - 1);
         src = m_pend ? live : m_snap;
         sdp = m_pend ? ldp : m_sdp;
         v = src[m_idx];
         blank = blank_lz && ((m_idx == 3 && src[3] == 0) || (m_idx == 2 && src[3] == 0 && src[2] == 0));
         e_an = 4'hF ^ (4'(1) << m_idx);
         e_seg = blank ? 7'h7F : (v > 9 ? 7'b0111111 : pat[v]);
         e_dp = !sdp[m_idx];
         if (m_pend || (tick && m_idx == 3)) begin
            m_snap = live; m_sdp = ldp; m_pend = 0;
         end
         m_cnt = (m_cnt + 1) % DIV;
         if (tick) m_idx = (m_idx + 1) % 4;
      end else begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1;
      end
      @(posedge clk);
      #1;
      chk("an", {4'd0, an}, {4'd0, e_an});
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'd0, dp}, {7'd0, e_dp});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic run_to(input int idx, input int cnt);
      for (int i = 0; i < 40 && !(m_idx == idx && m_cnt == cnt); i++) cyc();
      chk("reach_slot", 8'(m_idx * 16 + m_cnt), 8'(idx * 16 + cnt));
   endtask

   initial begin
      pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      rst = 0; en = 0; blank_lz = 0; dp_mask = 0;
      {d3, d2, d1, d0} = 16'h1234;
      run(2);
      chk("reset_an", {4'd0, an}, 8'h0F);
      chk("reset_seg", {1'b0, seg}, 8'h7F);
      rst = 1; en = 1;
      cyc();
      chk("first_digit0", {1'b0, seg}, 8'b0011001);
      run(19);
      run_to(2, 0);
      d0 = 4'd9;
      run(16);
      {d3, d2, d1, d0} = 16'h0005; blank_lz = 1;
      run(20);
      blank_lz = 0;
      run(16);
      {d3, d2, d1, d0} = 16'h12C4; dp_mask = 4'b0010;
      run(20);
      run_to(2, 1);
      en = 0;
      cyc();
      chk("en_low_dark", {4'd0, an}, 8'h0F);
      run(9);
      en = 1;
      run(12);
      run_to(3, 2);
      rst = 0;
      cyc();
      chk("rst_dark", {4'd0, an}, 8'h0F);
      rst = 1;
      cyc();
      chk("rst_digit0", {4'd0, an}, 8'h0E);
      run(12);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) {d3, d2, d1, d0} = 16'($urandom);
         if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
         en = $urandom_range(0, 9) != 0;
         rst = $urandom_range(0, 99) != 0;
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
